wb_regfile: RTL and testbench
=============================

Name: wb_regfile

Overview:
- Write-back end of the MEM/WB pipeline interface, merged with the architectural register file.
- Consumes the MEM/WB outputs and selects the write-back value: memory data or ALU result.
- Commits that value to a 32x32 register file and serves the two ID-stage read ports (rs, rt).
- Exposes the selected write-back word for the forwarding unit, plus a retired-write counter for debug and performance.

Parameters:
- DATA_W, 32, width of data path and of every register.
- ADDR_W, 5, register address width.
- NREGS, 32, number of architectural registers; must equal 2**ADDR_W.
- CNT_W, 32, width of the retired-write counter.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset, synchronous, active-high.
- reg_write  in  1  write-back enable from MEM/WB.
- mem_to_reg  in  1  1 selects read_data, 0 selects alu_result.
- read_data  in  DATA_W  load data from MEM/WB.
- dst_reg  in  ADDR_W  destination register from MEM/WB.
- alu_result  in  DATA_W  ALU result from MEM/WB.
- rs_addr  in  ADDR_W  read port A address (ID stage).
- rt_addr  in  ADDR_W  read port B address (ID stage).
- rs_data  out  DATA_W  read port A data.
- rt_data  out  DATA_W  read port B data.
- wb_data  out  DATA_W  selected write-back value, for forwarding.
- wb_count  out  CNT_W  number of committed writes since reset.

Behaviour:
- wb_data is combinational: mem_to_reg ? read_data : alu_result. It is valid whenever the inputs are, including during reset.
- Commit: on the rising edge with rst=0, reg_write=1 and dst_reg!=0, regs[dst_reg] <= wb_data. Latency is 1 cycle; the new value is visible on the read ports the next cycle (same cycle only with the optional bypass).
- Register 0 is hardwired to zero:
  - writes to dst_reg=0 are discarded;
  - reads of address 0 always return 0, irrespective of bypass.
- Reads are asynchronous and combinational. rs and rt may address the same register; both ports return the same value.
- wb_count:
  - increments by 1 on each rising edge with rst=0, reg_write=1 and dst_reg!=0;
  - writes to $0 are not counted;
  - wraps from 2**CNT_W-1 to 0 with no flag.
- Reset: when rst=1 at a rising edge, all NREGS registers and wb_count clear to 0 in that cycle. The write and count requested in the same cycle are dropped; reset wins.
- Reset mid-operation: no partial state remains. The first post-reset write is accepted on the first edge with rst=0.
- Outputs after reset: rs_data=0, rt_data=0, wb_count=0. wb_data follows its inputs.
- The block has no handshake and no stall input. Every edge with reg_write=1 commits. Upstream guarantees that a bubble carries reg_write=0.
- X handling: if reg_write=0, dst_reg and the data inputs are don't-care and must not affect state.

Optional Feature:
- Macro WB_REGFILE_BYPASS_EN.
- Defined:
  - if reg_write=1, dst_reg!=0 and rs_addr==dst_reg, then rs_data=wb_data in the same cycle; rt behaves the same with rt_addr;
  - this removes the 3-instruction write/read hazard window;
  - the bypass is suppressed while rst=1.
- Undefined: read ports return stored contents only. The hazard unit must stall one extra cycle on a WB/ID match.

Decomposition:
- Shared package/header holds WORD_ZERO, REG_ZERO_ADDR (5'd0), DATA_W/ADDR_W defaults and the mem_to_reg encoding constants.
- One sub-module: wb_mux, the 2:1 write-back select. It is reused by the forwarding unit so that both blocks apply the same selection.
- The storage array and the counter stay in wb_regfile.

Test Plan:
- Reset: assert rst 2 cycles after random preload, then deassert -> every rs/rt read of 0..31 returns 0, and wb_count=0.
- ALU write: reg_write=1, mem_to_reg=0, alu_result=32'hDEADBEEF, dst_reg=5; next cycle rs_addr=5 -> rs_data=32'hDEADBEEF, wb_count=1.
- Load write: mem_to_reg=1, read_data=32'h12345678, alu_result=32'hFFFFFFFF, dst_reg=31 -> rt_data on r31=32'h12345678 next cycle; wb_data=32'h12345678 in the write cycle.
- $0 write: reg_write=1, dst_reg=0, value 32'hA5A5A5A5 -> rs_addr=0 reads 0, and wb_count is unchanged.
- Same-cycle hazard: write 32'h00000042 to r7 with rs_addr=rt_addr=7 in the same cycle -> bypass build returns 32'h42 that cycle; non-bypass build returns the old value, then 32'h42 next cycle.
- Reset collision and wrap:
  - rst=1 together with a write to r3 -> r3 reads 0 after reset;
  - with CNT_W=4, 17 committed writes -> wb_count=1.

Source files
------------

// File: rtl/wb_regfile_pkg.sv
// Shared constants for the write-back stage and register file.
// Used by wb_regfile, wb_mux and the forwarding unit.
package wb_regfile_pkg;

    localparam int unsigned DATA_W_DEF = 32;
    localparam int unsigned ADDR_W_DEF = 5;

    localparam logic [DATA_W_DEF-1:0] WORD_ZERO     = '0;
    localparam logic [ADDR_W_DEF-1:0] REG_ZERO_ADDR = 5'd0;

    // mem_to_reg encoding
    typedef enum logic {
        WB_SEL_ALU = 1'b0,
        WB_SEL_MEM = 1'b1
    } wb_sel_e;

endpackage

// File: rtl/wb_regfile_mux.sv
// 2:1 write-back select (memory data vs ALU result).
// Shared with the forwarding unit so both apply the identical selection.
module wb_mux
    import wb_regfile_pkg::*;
#(
    parameter int unsigned DATA_W = DATA_W_DEF
) (
    input  logic              sel_i,
    input  logic [DATA_W-1:0] mem_data_i,
    input  logic [DATA_W-1:0] alu_data_i,
    output logic [DATA_W-1:0] data_o
);

    always_comb begin
        data_o = alu_data_i;
        if (wb_sel_e'(sel_i) == WB_SEL_MEM) begin
            data_o = mem_data_i;
        end
    end

endmodule

// File: rtl/wb_regfile.sv
// MEM/WB write-back end merged with the 32x32 register file and a retired-write counter.
// Optional same-cycle WB->ID bypass: define WB_REGFILE_BYPASS_EN.
module wb_regfile
    import wb_regfile_pkg::*;
#(
    parameter int unsigned DATA_W = DATA_W_DEF,
    parameter int unsigned ADDR_W = ADDR_W_DEF,
    parameter int unsigned NREGS  = 32,
    parameter int unsigned CNT_W  = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              reg_write,
    input  logic              mem_to_reg,
    input  logic [DATA_W-1:0] read_data,
    input  logic [ADDR_W-1:0] dst_reg,
    input  logic [DATA_W-1:0] alu_result,
    input  logic [ADDR_W-1:0] rs_addr,
    input  logic [ADDR_W-1:0] rt_addr,
    output logic [DATA_W-1:0] rs_data,
    output logic [DATA_W-1:0] rt_data,
    output logic [DATA_W-1:0] wb_data,
    output logic [CNT_W-1:0]  wb_count
);

    localparam logic [ADDR_W-1:0] ZERO_ADDR = ADDR_W'(REG_ZERO_ADDR);

    logic [DATA_W-1:0] regs_q [NREGS];
    logic [DATA_W-1:0] regs_d [NREGS];
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              commit;

    wb_mux #(.DATA_W(DATA_W)) u_wb_mux (
        .sel_i      (mem_to_reg),
        .mem_data_i (read_data),
        .alu_data_i (alu_result),
        .data_o     (wb_data)
    );

    // Writes to $0 are neither stored nor counted.
    assign commit = reg_write && (dst_reg != ZERO_ADDR);

    always_comb begin
        regs_d = regs_q;
        cnt_d  = cnt_q;
        if (commit) begin
            regs_d[dst_reg] = wb_data;
            cnt_d           = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            regs_q <= '{default: '0};
            cnt_q  <= '0;
        end else begin
            regs_q <= regs_d;
            cnt_q  <= cnt_d;
        end
    end

    assign wb_count = cnt_q;

    always_comb begin
        rs_data = '0;
        rt_data = '0;
        if (rs_addr != ZERO_ADDR) begin
            rs_data = regs_q[rs_addr];
`ifdef WB_REGFILE_BYPASS_EN
            if (!rst && commit && (rs_addr == dst_reg)) begin
                rs_data = wb_data;
            end
`endif
        end
        if (rt_addr != ZERO_ADDR) begin
            rt_data = regs_q[rt_addr];
`ifdef WB_REGFILE_BYPASS_EN
            if (!rst && commit && (rt_addr == dst_reg)) begin
                rt_data = wb_data;
            end
`endif
        end
    end

endmodule

// File: tb/tb_wb_regfile.sv
// Directed self-checking bench for wb_regfile (default and CNT_W=4 instances).
// Expectations adapt to WB_REGFILE_BYPASS_EN when that macro is defined.
module tb_wb_regfile;

    logic        clk = 1'b0;
    logic        rst;
    logic        reg_write;
    logic        mem_to_reg;
    logic [31:0] read_data;
    logic [4:0]  dst_reg;
    logic [31:0] alu_result;
    logic [4:0]  rs_addr;
    logic [4:0]  rt_addr;
    logic [31:0] rs_data, rt_data, wb_data, wb_count;
    logic [31:0] rs_data4, rt_data4, wb_data4;
    logic [3:0]  wb_count4;

    int unsigned tests_run    = 0;
    int unsigned tests_failed = 0;

    always #5 clk = ~clk;

    wb_regfile dut (
        .clk        (clk),
        .rst        (rst),
        .reg_write  (reg_write),
        .mem_to_reg (mem_to_reg),
        .read_data  (read_data),
        .dst_reg    (dst_reg),
        .alu_result (alu_result),
        .rs_addr    (rs_addr),
        .rt_addr    (rt_addr),
        .rs_data    (rs_data),
        .rt_data    (rt_data),
        .wb_data    (wb_data),
        .wb_count   (wb_count)
    );

    wb_regfile #(.CNT_W(4)) dut4 (
        .clk        (clk),
        .rst        (rst),
        .reg_write  (reg_write),
        .mem_to_reg (mem_to_reg),
        .read_data  (read_data),
        .dst_reg    (dst_reg),
        .alu_result (alu_result),
        .rs_addr    (rs_addr),
        .rt_addr    (rt_addr),
        .rs_data    (rs_data4),
        .rt_data    (rt_data4),
        .wb_data    (wb_data4),
        .wb_count   (wb_count4)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Advance past the next rising edge; inputs/outputs are handled 1 time unit later.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic write_reg(input logic [4:0] dst, input logic [31:0] val);
        reg_write  = 1'b1;
        mem_to_reg = 1'b0;
        alu_result = val;
        read_data  = ~val;
        dst_reg    = dst;
        step();
        reg_write  = 1'b0;
    endtask

    logic [31:0] exp_hz;

    initial begin
        rst = 1'b1; reg_write = 1'b0; mem_to_reg = 1'b0;
        read_data = '0; alu_result = '0; dst_reg = '0; rs_addr = '0; rt_addr = '0;
        step();
        rst = 1'b0;

        // Random preload of r1..r31, then a 2-cycle reset.
        for (int i = 1; i < 32; i++) begin
            write_reg(5'(i), $urandom);
        end
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        for (int i = 0; i < 32; i++) begin
            rs_addr = 5'(i);
            rt_addr = 5'(31 - i);
            #1;
            check("reset_rs", rs_data, 32'h0);
            check("reset_rt", rt_data, 32'h0);
        end
        check("reset_cnt", wb_count, 32'd0);
        check("reset_cnt4", {28'h0, wb_count4}, 32'd0);

        // ALU write to r5.
        reg_write = 1'b1; mem_to_reg = 1'b0; alu_result = 32'hDEADBEEF;
        read_data = 32'h0BAD0BAD; dst_reg = 5'd5;
        #1;
        check("alu_wbdata", wb_data, 32'hDEADBEEF);
        step();
        reg_write = 1'b0; rs_addr = 5'd5;
        #1;
        check("alu_rs", rs_data, 32'hDEADBEEF);
        check("alu_cnt", wb_count, 32'd1);

        // Load write to r31.
        reg_write = 1'b1; mem_to_reg = 1'b1; read_data = 32'h12345678;
        alu_result = 32'hFFFFFFFF; dst_reg = 5'd31;
        #1;
        check("load_wbdata", wb_data, 32'h12345678);
        step();
        reg_write = 1'b0; rt_addr = 5'd31;
        #1;
        check("load_rt", rt_data, 32'h12345678);
        check("load_cnt", wb_count, 32'd2);

        // Write to $0 is discarded and uncounted; $0 reads zero even in the write cycle.
        reg_write = 1'b1; mem_to_reg = 1'b0; alu_result = 32'hA5A5A5A5;
        dst_reg = 5'd0; rs_addr = 5'd0;
        #1;
        check("r0_during", rs_data, 32'h0);
        step();
        reg_write = 1'b0;
        #1;
        check("r0_after", rs_data, 32'h0);
        check("r0_cnt", wb_count, 32'd2);

        // Same-cycle write/read hazard on r7 (old value 0).
        reg_write = 1'b1; mem_to_reg = 1'b0; alu_result = 32'h00000042;
        dst_reg = 5'd7; rs_addr = 5'd7; rt_addr = 5'd7;
`ifdef WB_REGFILE_BYPASS_EN
        exp_hz = 32'h42;
`else
        exp_hz = 32'h0;
`endif
        #1;
        check("hazard_rs_same", rs_data, exp_hz);
        check("hazard_rt_same", rt_data, exp_hz);
        step();
        reg_write = 1'b0;
        #1;
        check("hazard_rs_next", rs_data, 32'h42);
        check("hazard_rt_next", rt_data, 32'h42);
        check("hazard_cnt", wb_count, 32'd3);

        // reg_write=0: other inputs must not affect state.
        reg_write = 1'b0; dst_reg = 5'd5; alu_result = 32'h11112222; rs_addr = 5'd5;
        step();
        #1;
        check("idle_rs", rs_data, 32'hDEADBEEF);
        check("idle_cnt", wb_count, 32'd3);

        // Reset collides with a write to r3; bypass is suppressed during reset.
        write_reg(5'd3, 32'h33);
        rst = 1'b1; reg_write = 1'b1; mem_to_reg = 1'b0; alu_result = 32'h99;
        dst_reg = 5'd3; rs_addr = 5'd3;
        #1;
        check("rstcol_during", rs_data, 32'h33);
        step();
        rst = 1'b0; reg_write = 1'b0;
        #1;
        check("rstcol_r3", rs_data, 32'h0);
        check("rstcol_cnt", wb_count, 32'd0);
        check("rstcol_cnt4", {28'h0, wb_count4}, 32'd0);

        // First edge after reset accepts a write.
        write_reg(5'd4, 32'h44);
        rs_addr = 5'd4;
        #1;
        check("postrst_r4", rs_data, 32'h44);
        check("postrst_cnt", wb_count, 32'd1);

        // 16 more commits: 17 total, the 4-bit counter wraps to 1.
        for (int i = 0; i < 16; i++) begin
            write_reg(5'(10 + i), 32'h100 + 32'(i));
        end
        rs_addr = 5'd10; rt_addr = 5'd25;
        #1;
        check("wrap_r10", rs_data, 32'h100);
        check("wrap_r25", rt_data, 32'h10F);
        check("wrap_cnt", wb_count, 32'd17);
        check("wrap_cnt4", {28'h0, wb_count4}, 32'd1);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
